water_distribution_controller: RTL and testbench

//  Consumer-side counterpart to the reservoir filler: periodically computes city and town

---
 rtl/water_distribution_controller.sv | 122 ++++++++++++
 tb/tb_water_distribution_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/water_distribution_controller.sv
// water_distribution_controller: periodic city/town demand evaluation with reserve-protected,
// city-first rationing, served to the reservoir over a req/ack drain port.
module water_distribution_controller #(
    parameter int DEMAND_PERIOD = 8,
    parameter int CITY_PER_CAP  = 2,
    parameter int TOWN_PER_CAP  = 1,
    parameter int RESERVE_LEVEL = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] city_population,
    input  logic [7:0] town_population,
    input  logic [9:0] reservoir_level,
    input  logic       drain_ack,
    output logic       drain_req,
    output logic [9:0] drain_amount,
    output logic       drain_target,
    output logic       shortage,
    output logic [9:0] city_shortfall,
    output logic [9:0] town_shortfall,
    output logic       cycle_done,
    output logic       overrun
);
    localparam int CW = $clog2(DEMAND_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(DEMAND_PERIOD - 1);
    localparam logic [9:0] RES = 10'(RESERVE_LEVEL);

    typedef enum logic [1:0] {IDLE, CALC, SERVE_CITY, SERVE_TOWN} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0] cd_q, cd_d, td_q, td_d, cg_q, cg_d, tg_q, tg_d;
    logic [9:0] city_sf_q, city_sf_d, town_sf_q, town_sf_d;
    logic shortage_q, shortage_d, done_q, done_d, overrun_q, overrun_d;
    logic tick;
    logic [17:0] city_prod, town_prod;
    logic [9:0] avail, cg, rem, tg;

    assign tick      = cnt_q == LAST;
    assign city_prod = 18'(city_population) * 18'(CITY_PER_CAP);
    assign town_prod = 18'(town_population) * 18'(TOWN_PER_CAP);
    // Grants only matter in CALC, where cd_q/td_q already hold this evaluation's demand.
    assign avail = reservoir_level > RES ? reservoir_level - RES : 10'd0;
    assign cg    = cd_q < avail ? cd_q : avail;
    assign rem   = avail - cg;
    assign tg    = td_q < rem ? td_q : rem;

    always_comb begin
        state_d    = state_q;
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        cd_d       = cd_q;
        td_d       = td_q;
        cg_d       = cg_q;
        tg_d       = tg_q;
        city_sf_d  = city_sf_q;
        town_sf_d  = town_sf_q;
        shortage_d = shortage_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q | (tick & (state_q != IDLE));
        case (state_q)
            IDLE: if (tick) begin
                cd_d    = |city_prod[17:10] ? 10'h3FF : city_prod[9:0];
                td_d    = |town_prod[17:10] ? 10'h3FF : town_prod[9:0];
                state_d = CALC;
            end
            CALC: begin
                cg_d       = cg;
                tg_d       = tg;
                shortage_d = (cg < cd_q) | (tg < td_q);
                city_sf_d  = cd_q - cg;
                town_sf_d  = td_q - tg;
                state_d    = cg != 0 ? SERVE_CITY : tg != 0 ? SERVE_TOWN : IDLE;
                done_d     = (cg == 0) & (tg == 0);
            end
            SERVE_CITY: if (drain_ack) begin
                state_d = tg_q != 0 ? SERVE_TOWN : IDLE;
                done_d  = tg_q == 0;
            end
            default: if (drain_ack) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cd_q       <= '0;
            td_q       <= '0;
            cg_q       <= '0;
            tg_q       <= '0;
            city_sf_q  <= '0;
            town_sf_q  <= '0;
            shortage_q <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cd_q       <= cd_d;
            td_q       <= td_d;
            cg_q       <= cg_d;
            tg_q       <= tg_d;
            city_sf_q  <= city_sf_d;
            town_sf_q  <= town_sf_d;
            shortage_q <= shortage_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign drain_req      = (state_q == SERVE_CITY) | (state_q == SERVE_TOWN);
    assign drain_target   = state_q == SERVE_TOWN;
    assign drain_amount   = state_q == SERVE_CITY ? cg_q : state_q == SERVE_TOWN ? tg_q : 10'd0;
    assign shortage       = shortage_q;
    assign city_shortfall = city_sf_q;
    assign town_shortfall = town_sf_q;
    assign cycle_done     = done_q;
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_water_distribution_controller.sv
// tb_water_distribution_controller: randomized and directed stimulus checked against a
// transaction-level model (pending-transfer queue, arithmetic grants) of the controller.
module tb_water_distribution_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] city_population = '0;
    logic [7:0] town_population = '0;
    logic [9:0] reservoir_level = '0;
    logic       drain_ack = 1'b0;
    logic       drain_req, drain_target, shortage, cycle_done, overrun;
    logic [9:0] drain_amount, city_shortfall, town_shortfall;

    water_distribution_controller dut (
        .clk(clk), .reset(reset),
        .city_population(city_population), .town_population(town_population),
        .reservoir_level(reservoir_level), .drain_ack(drain_ack),
        .drain_req(drain_req), .drain_amount(drain_amount), .drain_target(drain_target),
        .shortage(shortage), .city_shortfall(city_shortfall), .town_shortfall(town_shortfall),
        .cycle_done(cycle_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int ack_mode = 1;
    int m_cnt = 0, m_cd = 0, m_td = 0, m_csf = 0, m_tsf = 0, m_xfers = 0, d_xfers = 0;
    bit m_calc = 0, m_short = 0, m_done = 0, m_ovr = 0;
    int qa[$];
    bit qt[$];

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return a < b ? a : b;
    endfunction

    // Reference model: demands become a list of pending transfers served in order.
    always @(posedge clk) begin
        int avail, cg, tg;
        bit idle, tick;
        if (!reset && drain_req && drain_ack) d_xfers++;
        if (reset) begin
            m_cnt = 0; m_cd = 0; m_td = 0; m_csf = 0; m_tsf = 0;
            m_calc = 0; m_short = 0; m_done = 0; m_ovr = 0;
            qa.delete(); qt.delete();
        end else begin
            idle   = !m_calc && qa.size() == 0;
            tick   = m_cnt == 7;
            m_cnt  = (m_cnt + 1) % 8;
            m_done = 0;
            if (m_calc) begin
                avail   = reservoir_level > 16 ? reservoir_level - 16 : 0;
                cg      = imin(m_cd, avail);
                tg      = imin(m_td, avail - cg);
                m_short = (cg < m_cd) || (tg < m_td);
                m_csf   = m_cd - cg;
                m_tsf   = m_td - tg;
                if (cg > 0) begin qa.push_back(cg); qt.push_back(0); end
                if (tg > 0) begin qa.push_back(tg); qt.push_back(1); end
                m_done  = cg == 0 && tg == 0;
                m_calc  = 0;
            end else if (qa.size() > 0 && drain_ack) begin
                void'(qa.pop_front());
                void'(qt.pop_front());
                m_xfers++;
                m_done = qa.size() == 0;
            end
            if (tick) begin
                if (idle) begin
                    m_cd   = imin(city_population * 2, 1023);
                    m_td   = imin(int'(town_population), 1023);
                    m_calc = 1;
                end else m_ovr = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("req", drain_req, qa.size() > 0);
        check("amount", drain_amount, qa.size() > 0 ? qa[0] : 0);
        check("target", drain_target, qt.size() > 0 ? qt[0] : 0);
        check("shortage", shortage, m_short);
        check("city_sf", city_shortfall, m_csf);
        check("town_sf", town_shortfall, m_tsf);
        check("cycle_done", cycle_done, m_done);
        check("overrun", overrun, m_ovr);
        case (ack_mode)
            0: drain_ack = 1'b0;
            1: drain_ack = 1'b1;
            2: drain_ack = 1'($urandom_range(0, 1));
            default: drain_ack = drain_req && !drain_target;
        endcase
    end

    task automatic set_in(input int c, input int t, input int l);
        city_population = 8'(c);
        town_population = 8'(t);
        reservoir_level = 10'(l);
    endtask

    initial begin
        int n, x0;
        set_in(20, 10, 200);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!drain_req && n < 30);
        check("first_req_edges", n, 9);
        repeat (16) @(negedge clk);

        set_in(50, 30, 100);
        repeat (20) @(negedge clk);
        check("t3_shortage", shortage, 1);
        check("t3_city_sf", city_shortfall, 16);
        check("t3_town_sf", town_shortfall, 30);

        set_in(5, 5, 10);
        repeat (20) @(negedge clk);
        check("t4_shortage", shortage, 1);
        check("t4_city_sf", city_shortfall, 10);
        check("t4_town_sf", town_shortfall, 5);

        set_in(20, 10, 200);
        ack_mode = 0;
        n = 0;
        while (!drain_req && n < 30) begin @(negedge clk); n++; end
        check("t5_req_seen", drain_req, 1);
        x0 = d_xfers;
        repeat (20) @(negedge clk);
        check("t5_amount_held", drain_amount, 40);
        check("t5_overrun", overrun, 1);
        set_in(0, 0, 200);
        ack_mode = 1;
        repeat (4) @(negedge clk);
        check("t5_xfers", d_xfers - x0, 2);

        set_in(20, 10, 200);
        ack_mode = 3;
        n = 0;
        while (!(drain_req && drain_target) && n < 40) begin @(negedge clk); n++; end
        check("t6_in_town", drain_req && drain_target, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_req_dropped", drain_req, 0);
        check("t6_no_done", cycle_done, 0);
        check("t6_overrun_clr", overrun, 0);

        ack_mode = 2;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0)
                set_in($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 700));
            reset = $urandom_range(0, 149) == 0;
            @(negedge clk);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("xfer_count", d_xfers, m_xfers);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
